// File: rtl/alu_bit_serial_pkg.sv
// Shared types and op codes for the bit-serial ALU.
// Imported by the slice, the top and the bench.
package alu_bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_bit_serial_if.sv
// Request/response bundle between operand fetch,
// the bit-serial ALU and writeback.
interface alu_bit_serial_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, op, a, b,
    input  busy, done, result,
    input  zero, overflow, carry_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result,
    output zero, overflow, carry_out
  );

endinterface

// File: rtl/alu_bit_serial_slice.sv
// Classic 1-bit ALU slice: invert/negate inputs,
// then AND / OR / full-add / pass-less.
module alu_bit_serial_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [3:0] sel,
  output logic       out,
  output logic       cout,
  output logic       set
);

  logic ai;
  logic bi;
  logic sum;

  assign ai   = a ^ sel[3];
  assign bi   = b ^ sel[2];
  assign sum  = ai ^ bi ^ cin;
  assign cout = (ai & bi) | (ai & cin)
              | (bi & cin);
  assign set  = sum;

  // Output mux on the low op bits.
  always_comb begin
    out = 1'b0;
    unique case (sel[1:0])
      2'b00: out = ai & bi;
      2'b01: out = ai | bi;
      2'b10: out = sum;
      2'b11: out = less;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial execute unit: one WIDTH-bit op in
// WIDTH cycles through a single 1-bit slice.
module alu_bit_serial
  import alu_bit_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_bit_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:1] res_sh;
  logic [3:0]       op_q;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;

  logic             s_out;
  logic             s_cout;
  logic             s_set;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fin;
  logic             arith;
  logic             slt;
  logic             ovf;

  alu_bit_serial_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (cy),
    .less (1'b0),
    .sel  (op_q),
    .out  (s_out),
    .cout (s_cout),
    .set  (s_set)
  );

  assign shifted = {s_out, res_sh};
  assign arith   = (op_q[1:0] == 2'b10);
  assign slt     = (op_q[1:0] == 2'b11);
  assign ovf     = cy ^ s_cout;
  assign fin     = slt
    ? {{(WIDTH-1){1'b0}}, s_set ^ ovf}
    : shifted;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and accept/last strobes.
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    last   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          nxt    = RUN;
        end
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept = 1'b1;
          nxt    = RUN;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand shift, carry recirculation, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      op_q <= bus.op;
      cy   <= bus.op[2];
      cnt  <= '0;
    end else if (state == RUN) begin
      res_sh <= shifted[WIDTH-1:1];
      cy     <= s_cout;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        res_q  <= fin;
        zero_q <= (fin == '0);
        ovf_q  <= arith & ovf;
        cout_q <= arith & s_cout;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule
